coriolis_ker_cmul_lanes: RTL

- Multi-lane, fully parametrised successor to the single-lane constant-multiply leaf map node. LANES lanes of signed fixed-point data are multiplied by a shared, runtime-loadable coefficient.
- Valid tracking is per pipeline stage. A credit-gated output FIFO means iready never depends combinationally on oready.
- Sits between stream-fabric stages in generated kernels (e.g. the Coriolis rotation terms).

---
 rtl/coriolis_ker_pkg.sv | 42 ++++
 rtl/coriolis_cmul_lane.sv | 72 +++++++
 rtl/coriolis_ker_cmul_lanes.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/coriolis_ker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coriolis_ker_pkg
//  Description : Shared helpers for the multi-lane constant-multiply node:
//                lane slicing, rounding constant, counter/pointer widths and
//                saturation bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
package coriolis_ker_pkg;

  // LSB position of lane k inside a packed lane bus
  function automatic int lane_lsb(input int k, input int dataw);
    return k * dataw;
  endfunction

  // Width of a counter that must hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a FIFO pointer (at least one bit)
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Half an LSB of the result, added before the fraction is shifted out
  function automatic longint rnd_const(input int fracw);
    return (fracw > 0) ? (longint'(1) <<< (fracw - 1)) : 64'sd0;
  endfunction

  // Largest representable signed value of a dataw-bit lane
  function automatic longint sat_max(input int dataw);
    return (longint'(1) <<< (dataw - 1)) - 64'sd1;
  endfunction

  // Smallest representable signed value of a dataw-bit lane
  function automatic longint sat_min(input int dataw);
    return -(longint'(1) <<< (dataw - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/coriolis_cmul_lane.sv
`default_nettype none
// ============================================================================
//  Module      : coriolis_cmul_lane
//  Description : One lane of the constant multiplier. LAT registered stages
//                carry the full-width product; the last stage is rounded
//                half toward +inf and wrapped, or clamped when CMUL_SAT_EN
//                is defined (which also adds the clamp_o port).
//  Revision    : 1.0 - initial release
// ============================================================================
module coriolis_cmul_lane
  import coriolis_ker_pkg::*;
#(
  parameter int DATAW = 18,
  parameter int COEFW = 18,
  parameter int FRACW = 14,
  parameter int LAT   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic signed [DATAW-1:0] data_i,
  input  logic signed [COEFW-1:0] coef_i,
  output logic signed [DATAW-1:0] res_o
`ifdef CMUL_SAT_EN
  ,
  output logic                    clamp_o
`endif
);

  localparam int PW = DATAW + COEFW;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] c_RND = RW'(rnd_const(FRACW));
`ifdef CMUL_SAT_EN
  localparam logic signed [RW-1:0] c_MAX = RW'(sat_max(DATAW));
  localparam logic signed [RW-1:0] c_MIN = RW'(sat_min(DATAW));
`endif

  logic signed [PW-1:0] prod_q [LAT];
  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_shr;

  // Stage 0 captures the product on accept; later stages shift every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) prod_q[i] <= '0;
    end else begin
      if (load_i) prod_q[0] <= PW'(data_i) * PW'(coef_i);
      for (int i = 1; i < LAT; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  // Round half toward +inf, drop the fraction, then wrap or clamp
  always_comb begin
    w_sum = RW'(prod_q[LAT-1]) + c_RND;
    w_shr = w_sum >>> FRACW;
`ifdef CMUL_SAT_EN
    clamp_o = 1'b0;
    res_o   = DATAW'(w_shr);
    if (w_shr > c_MAX) begin
      res_o   = DATAW'(c_MAX);
      clamp_o = 1'b1;
    end else if (w_shr < c_MIN) begin
      res_o   = DATAW'(c_MIN);
      clamp_o = 1'b1;
    end
`else
    res_o = DATAW'(w_shr);
`endif
  end

endmodule
`default_nettype wire

// File: rtl/coriolis_ker_cmul_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : coriolis_ker_cmul_lanes
//  Description : LANES-wide signed multiply by a shared runtime-loadable
//                coefficient. Non-stalling LAT-stage pipeline feeding a
//                credit-gated output FIFO, so iready is a function of
//                registered counters only.
//                Optional macro CMUL_SAT_EN: saturate instead of wrap and
//                add the sticky sat_flag output.
//  Revision    : 1.0 - initial release
// ============================================================================
module coriolis_ker_cmul_lanes
  import coriolis_ker_pkg::*;
#(
  parameter int                      LANES      = 4,
  parameter int                      DATAW      = 18,
  parameter int                      COEFW      = 18,
  parameter int                      FRACW      = 14,
  parameter logic signed [COEFW-1:0] COEF_RST   = 18'sh3FF0,
  parameter int                      LAT        = 3,
  parameter int                      FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ivalid,
  output logic                   iready,
  input  logic [LANES*DATAW-1:0] in_data,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [LANES*DATAW-1:0] out_data,
  input  logic                   coef_wr,
  input  logic [COEFW-1:0]       coef_data,
  output logic                   busy
`ifdef CMUL_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int BW   = LANES * DATAW;
  localparam int CW   = cnt_w(FIFO_DEPTH);
  localparam int PTRW = ptr_w(FIFO_DEPTH);
  localparam logic [CW:0]     c_DEPTH    = (CW+1)'(FIFO_DEPTH);
  localparam logic [PTRW-1:0] c_PTR_LAST = PTRW'(FIFO_DEPTH - 1);

  logic signed [COEFW-1:0] coef_q;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [PTRW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]           mem_q [FIFO_DEPTH];
  logic [BW-1:0]           w_res;
  logic                    w_accept, w_push, w_pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + PTRW'(1);
  endfunction

  // Every beat is either in the pipe or in the FIFO, so their sum bounds
  // FIFO occupancy and no stall is ever needed.
  assign iready   = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < c_DEPTH;
  assign w_accept = ivalid & iready;
  assign w_push   = vld_q[LAT-1];
  assign ovalid   = (fifo_cnt_q != '0);
  assign w_pop    = ovalid & oready;
  assign out_data = mem_q[rd_ptr_q];
  assign busy     = (inflight_q != '0) | (fifo_cnt_q != '0);

`ifdef CMUL_SAT_EN
  logic [LANES-1:0] w_clamp;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    coriolis_cmul_lane #(
      .DATAW (DATAW),
      .COEFW (COEFW),
      .FRACW (FRACW),
      .LAT   (LAT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (w_accept),
      .data_i  (in_data[lane_lsb(k, DATAW) +: DATAW]),
      .coef_i  (coef_q),
      .res_o   (w_res[lane_lsb(k, DATAW) +: DATAW])
`ifdef CMUL_SAT_EN
      ,
      .clamp_o (w_clamp[k])
`endif
    );
  end

  // Next-state for valid shift register, counters and FIFO pointers
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = w_accept;
    inflight_d = inflight_q;
    case ({w_accept, w_push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    fifo_cnt_d = fifo_cnt_q;
    case ({w_push, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // Control state and coefficient register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_q     <= COEF_RST;
      vld_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (coef_wr) coef_q <= coef_data;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage, written from the last pipeline stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= w_res;
    end
  end

`ifdef CMUL_SAT_EN
  logic sat_q;

  // Sticky record of any lane clamping on a retiring beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (w_push && (w_clamp != '0)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`endif

endmodule
`default_nettype wire
